interconnect_cfg_loader: RTL
============================

// Module: interconnect_cfg_loader
// PURPOSE
//  Upstream configuration stage for the CLB interconnect muxes. Receives a serial bitstream,
//  deserialises NUM_MUX select words, checks them, and commits them to the interconnect_switch
//  buses that drive each interconnect mux.
//  Drives CLB_prgm_b so that the muxes pass data only while a verified configuration is held.
// PARAMETERS
//  NUM_MUX   4       number of interconnect muxes (LUT inputs) fed by this loader
//  SEL_W     6       select word width per mux
//  MAX_SEL   39      highest legal select code; 0-15 I, 16-23 Q, 24-31 RQ, 32-39 BY
//  SYNC      8'hA5   frame sync pattern
// PORTS
//  clk                 in   1              configuration clock
//  rst_b               in   1              asynchronous reset, active low
//  prgm_b              in   1              global program enable; 0 = load mode, 1 = user mode
//  cfg_din             in   1              serial bitstream, MSB first
//  cfg_valid           in   1              cfg_din valid
//  cfg_ready           out  1              loader accepts a bit; a bit transfers when valid & ready
//  interconnect_switch out  NUM_MUX*SEL_W  committed selects; mux i at [i*SEL_W +: SEL_W]
//  CLB_prgm_b          out  1              0 = committed config valid, muxes enabled
//  cfg_done            out  1              1-cycle pulse on successful commit
//  cfg_error           out  1              sticky; frame rejected
// BEHAVIOUR
//  Reset: FSM=IDLE, interconnect_switch=0, CLB_prgm_b=1, cfg_done=0, cfg_error=0, cfg_ready=0.
//  Frame: SYNC(8) | word0..word{NUM_MUX-1} (SEL_W each) | chk (SEL_W) = XOR of all words.
//  cfg_ready=1 only in IDLE/SHIFT/CHECK while prgm_b=0; it is 0 in COMMIT, ERROR and in user mode.
//  FSM:
//   IDLE   shift accepted bits into an 8-bit window; when the window equals SYNC, go to SHIFT,
//          set CLB_prgm_b=1 and clear cfg_error. The match on the Nth bit is usable on that
//          same edge.
//   SHIFT  shift bits into the shadow register; a bit counter counts NUM_MUX*SEL_W bits, then CHECK.
//   CHECK  shift SEL_W bits into chk. After the last bit: go to COMMIT if chk == XOR(words)
//          and every word <= MAX_SEL, else go to ERROR.
//   COMMIT one cycle. On the exit edge: interconnect_switch <= shadow, CLB_prgm_b <= 0,
//          cfg_done=1 for that cycle, then IDLE.
//   ERROR  one cycle. Set cfg_error=1, discard shadow, leave CLB_prgm_b=1, go to IDLE.
//  Latency: the final chk bit is accepted at edge k; outputs and the cfg_done pulse update at edge k+1.
//  Stalls: cfg_valid=0 holds all state; gaps between bits are unbounded.
//  prgm_b rising mid-frame (IDLE excluded): abort to IDLE. Discard shadow and counters.
//   Active selects and CLB_prgm_b keep their value (CLB_prgm_b is already 1 once sync was seen).
//  In user mode (prgm_b=1): FSM holds in IDLE and bits are ignored. Committed config persists.
//  Reconfiguration: a new SYNC raises CLB_prgm_b. Old selects stay on the bus until a new commit.
//  Asserting rst_b low at any time returns to reset values immediately.
//  SYNC bits that arrive inside the payload are plain data; sync is hunted only in IDLE.
// STRUCTURE
//  Shared package/include: SEL_W, MAX_SEL, SYNC, select-range constants (I/Q/RQ/BY bases),
//   and the FSM state encoding (3-bit localparams).
//  One sub-module, cfg_shift_reg: a parameterised serial-in, parallel-out register with
//   enable and clear. It is instantiated twice: the 8-bit sync window and the
//   NUM_MUX*SEL_W+SEL_W payload register.
// TESTING
//  1 Reset, then prgm_b=0 and frame A5 | 5,16,33,39 | chk 19 -> cfg_done once;
//    switch={39,33,16,5}; CLB_prgm_b=0.
//  2 Same frame with chk=18 -> cfg_error=1; CLB_prgm_b=1; switch unchanged (0).
//  3 Word value 40 with a correct XOR chk -> ERROR; no commit.
//  4 Frame 1, then prgm_b=1 after 12 payload bits -> FSM in IDLE; cfg_ready=0;
//    switch/CLB_prgm_b unchanged.
//  5 Random cfg_valid gaps (0-7 cycles), noise bits 0x5A before SYNC -> same result as test 1.
//  6 rst_b low during SHIFT -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/interconnect_cfg_loader_pkg.sv
// Shared constants and state encoding for the
// interconnect mux configuration loader.
package interconnect_cfg_loader_pkg;

  localparam int DEF_NUM_MUX = 4;
  localparam int SEL_W       = 6;
  localparam int MAX_SEL     = 39;
  localparam int SYNC_W      = 8;
  localparam logic [SYNC_W-1:0] SYNC = 8'hA5;

  localparam int I_BASE  = 0;
  localparam int Q_BASE  = 16;
  localparam int RQ_BASE = 24;
  localparam int BY_BASE = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_CHECK  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  function automatic logic sel_legal(
    input logic [SEL_W-1:0] s
  );
    return s <= SEL_W'(MAX_SEL);
  endfunction

endpackage

// File: rtl/interconnect_cfg_loader_shift.sv
// Serial-in parallel-out register, MSB first.
// Ports: clk, rst_b, en (shift), clr (zero), din, q.
module cfg_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         en,
  input  logic         clr,
  input  logic         din,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)   q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= {q[W-2:0], din};
  end

endmodule

// File: rtl/interconnect_cfg_loader.sv
// Serial loader for interconnect mux selects.
// Ports: clk, rst_b, prgm_b, cfg_din/valid/ready,
// interconnect_switch, CLB_prgm_b, cfg_done, cfg_error.
module interconnect_cfg_loader
  import interconnect_cfg_loader_pkg::*;
#(
  parameter int NUM_MUX = DEF_NUM_MUX
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     prgm_b,
  input  logic                     cfg_din,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  output logic [NUM_MUX*SEL_W-1:0] interconnect_switch,
  output logic                     CLB_prgm_b,
  output logic                     cfg_done,
  output logic                     cfg_error
);

  localparam int DATA_W = NUM_MUX * SEL_W;
  localparam int PAY_W  = DATA_W + SEL_W;
  localparam int CNT_W  = $clog2(PAY_W + 1);

  state_e state_q, state_d;

  logic accept;
  logic sync_hit;
  logic abort;
  logic last_data;
  logic last_chk;
  logic frame_ok;
  logic win_en, pay_en, pay_clr;

  // 7 stored bits plus the live bit form the
  // 8-bit sync window, so a match is seen on
  // the edge that accepts its last bit.
  logic [SYNC_W-2:0] win_q;
  logic [PAY_W-1:0]  pay_q;
  logic [PAY_W-1:0]  pay_nxt;
  logic [DATA_W-1:0] commit_sel;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign cfg_ready = rst_b && !prgm_b &&
    (state_q inside {ST_IDLE, ST_SHIFT, ST_CHECK});

  assign accept = cfg_valid && cfg_ready;

  assign sync_hit = (state_q == ST_IDLE) && accept &&
    ({win_q, cfg_din} == SYNC);

  assign abort = prgm_b &&
    (state_q inside {ST_SHIFT, ST_CHECK});

  assign last_data = accept && (state_q == ST_SHIFT) &&
    (cnt_q == CNT_W'(DATA_W - 1));

  assign last_chk = accept && (state_q == ST_CHECK) &&
    (cnt_q == CNT_W'(PAY_W - 1));

  assign win_en  = (state_q == ST_IDLE) && accept;
  assign pay_en  = accept &&
    (state_q inside {ST_SHIFT, ST_CHECK});
  assign pay_clr = sync_hit || abort ||
    (state_q inside {ST_COMMIT, ST_ERROR});

  cfg_shift_reg #(.W(SYNC_W - 1)) u_win (
    .clk   (clk),
    .rst_b (rst_b),
    .en    (win_en),
    .clr   (sync_hit),
    .din   (cfg_din),
    .q     (win_q)
  );

  cfg_shift_reg #(.W(PAY_W)) u_pay (
    .clk   (clk),
    .rst_b (rst_b),
    .en    (pay_en),
    .clr   (pay_clr),
    .din   (cfg_din),
    .q     (pay_q)
  );

  // Frame check looks at the payload including
  // the chk bit arriving on this edge.
  assign pay_nxt = {pay_q[PAY_W-2:0], cfg_din};

  always_comb begin
    logic [SEL_W-1:0] x;
    logic [SEL_W-1:0] w;
    logic             legal;
    x     = '0;
    legal = 1'b1;
    for (int i = 0; i < NUM_MUX; i++) begin
      w = pay_nxt[PAY_W-1-i*SEL_W -: SEL_W];
      x = x ^ w;
      if (!sel_legal(w)) legal = 1'b0;
    end
    frame_ok = legal && (x == pay_nxt[SEL_W-1:0]);
  end

  // word0 arrives first and lands on mux 0.
  always_comb begin
    commit_sel = '0;
    for (int i = 0; i < NUM_MUX; i++) begin
      commit_sel[i*SEL_W +: SEL_W] =
        pay_q[PAY_W-1-i*SEL_W -: SEL_W];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (pay_clr)     cnt_d = '0;
    else if (pay_en) cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sync_hit) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort)          state_d = ST_IDLE;
        else if (last_data) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (abort)
          state_d = ST_IDLE;
        else if (last_chk)
          state_d = frame_ok ? ST_COMMIT : ST_ERROR;
      end
      ST_COMMIT: state_d = ST_IDLE;
      ST_ERROR:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      interconnect_switch <= '0;
      CLB_prgm_b          <= 1'b1;
      cfg_done            <= 1'b0;
      cfg_error           <= 1'b0;
    end else begin
      cfg_done <= (state_q == ST_COMMIT);
      if (sync_hit) begin
        CLB_prgm_b <= 1'b1;
        cfg_error  <= 1'b0;
      end
      if (state_q == ST_COMMIT) begin
        interconnect_switch <= commit_sel;
        CLB_prgm_b          <= 1'b0;
      end
      if (state_q == ST_ERROR) cfg_error <= 1'b1;
    end
  end

endmodule
